// File: rtl/lsu_axi.sv
// Load/store unit bridging the in-order pipeline to AXI-lite data memory.
// Non-memory ops pass straight through; loads and stores latch the request,
// run one AXI-lite transaction and present the result in DONE until it is taken.
module lsu_axi (
  input  logic        clk,
  input  logic        rst,
  input  logic        prev_valid,
  output logic        this_ready,
  output logic        this_valid,
  input  logic        next_ready,
  input  logic        req,
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        access_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata_axi,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        accept_mem;

  assign accept_mem = (state_q == StIdle) && prev_valid && req;

  // Store lane placement: data replicated across lanes, strobe selects the target.
  always_comb begin
    st_data = wdata;
    st_strb = 4'b1111;
    case (funct3)
      3'b000: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      3'b001: begin
        st_data = {2{wdata[15:0]}};
        st_strb = 4'b0011 << {addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched request.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = rdata_axi[7:0];
      2'd1:    ld_byte = rdata_axi[15:8];
      2'd2:    ld_byte = rdata_axi[23:16];
      default: ld_byte = rdata_axi[31:24];
    endcase
    ld_half = addr_q[1] ? rdata_axi[31:16] : rdata_axi[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = rdata_axi;
    endcase
  end

  // Next-state logic; write-accept flags accumulate until both channels are done.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q | (awvalid & awready);
    w_done_d  = w_done_q | (wvalid & wready);
    case (state_q)
      StIdle: begin
        if (prev_valid && req) state_d = wen ? StWrReq : StRdAddr;
      end
      StRdAddr: begin
        if (arready) state_d = StRdData;
      end
      StRdData: begin
        if (rvalid) state_d = StDone;
      end
      StWrReq: begin
        if (aw_done_d && w_done_d) begin
          state_d   = StWrResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StWrResp: begin
        if (bvalid) state_d = StDone;
      end
      StDone: begin
        if (next_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request latches and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= 32'h0;
      funct3_q  <= 3'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept_mem) begin
        addr_q   <= addr;
        funct3_q <= funct3;
        wdata_q  <= st_data;
        wstrb_q  <= st_strb;
      end
      if (state_q == StRdData && rvalid) begin
        rdata_q <= (rresp != 2'b00) ? 32'h0 : ld_data;
        err_q   <= (rresp != 2'b00);
      end
      if (state_q == StWrResp && bvalid) begin
        rdata_q <= 32'h0;
        err_q   <= (bresp != 2'b00);
      end
    end
  end

  // AXI valids are pure state decodes so they never follow a ready combinationally.
  assign araddr    = {addr_q[31:2], 2'b00};
  assign arvalid   = (state_q == StRdAddr);
  assign rready    = (state_q == StRdData);
  assign awaddr    = {addr_q[31:2], 2'b00};
  assign awvalid   = (state_q == StWrReq) && !aw_done_q;
  assign wvalid    = (state_q == StWrReq) && !w_done_q;
  assign wdata_axi = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = (state_q == StWrResp);

  assign this_valid = ((state_q == StIdle) && prev_valid && !req) || (state_q == StDone);
  assign this_ready = this_valid && next_ready;
  assign rdata      = (state_q == StDone) ? rdata_q : 32'h0;
  assign access_err = (state_q == StDone) ? err_q : 1'b0;

endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi: AXI-lite slave model with per-channel ready delays and a
// result scoreboard filled when each instruction is issued.
module tb_lsu_axi;

  logic        clk = 1'b0;
  logic        rst, prev_valid, this_ready, this_valid, next_ready;
  logic        req, wen;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        access_err;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata_axi;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  lsu_axi dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .this_ready(this_ready),
    .this_valid(this_valid), .next_ready(next_ready), .req(req), .wen(wen),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .access_err(access_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata_axi(rdata_axi),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata_axi(wdata_axi), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Slave model state.
  logic [31:0] mem [0:15];
  int          ar_delay, aw_delay, w_delay, ar_cnt, aw_cnt, w_cnt;
  bit          r_pend, b_pend, r_block, aw_got, w_got;
  bit          ar_hs, aw_hs, w_hs, r_hs, b_hs, prev_ar, prev_aw, prev_w;
  logic [1:0]  resp_cfg;
  logic [31:0] r_word, last_araddr, hs_awaddr, hs_wdata, exp_wdata;
  logic [3:0]  hs_wstrb, exp_wstrb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = w[16*lane[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic slave_clear();
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    r_pend = 0; b_pend = 0; r_block = 0; aw_got = 0; w_got = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
    prev_ar = 0; prev_aw = 0; prev_w = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata_axi = 0; rresp = 0; bresp = 0;
  endtask

  // One clock of the slave: retire last edge's handshakes, check valid
  // persistence, then drive this cycle's responses.
  task automatic tick();
    @(negedge clk);
    if (ar_hs) begin
      check_eq("ar_drop", arvalid, 0);
      r_pend = 1;
      r_word = mem[last_araddr[5:2]];
    end else if (prev_ar) check_eq("ar_hold", arvalid, 1);
    if (aw_hs) begin
      check_eq("aw_drop", awvalid, 0);
      aw_got = 1;
    end else if (prev_aw) check_eq("aw_hold", awvalid, 1);
    if (w_hs) begin
      check_eq("w_drop", wvalid, 0);
      w_got = 1;
    end else if (prev_w) check_eq("w_hold", wvalid, 1);
    if (r_hs) r_pend = 0;
    if (b_hs) b_pend = 0;
    if (aw_got && w_got) begin
      for (int i = 0; i < 4; i++)
        if (hs_wstrb[i]) mem[hs_awaddr[5:2]][8*i +: 8] = hs_wdata[8*i +: 8];
      b_pend = 1;
      aw_got = 0;
      w_got  = 0;
    end
    arready = arvalid && (ar_cnt >= ar_delay);
    ar_cnt  = (arvalid && !arready) ? ar_cnt + 1 : 0;
    awready = awvalid && (aw_cnt >= aw_delay);
    aw_cnt  = (awvalid && !awready) ? aw_cnt + 1 : 0;
    wready  = wvalid && (w_cnt >= w_delay);
    w_cnt   = (wvalid && !wready) ? w_cnt + 1 : 0;
    rvalid    = r_pend && !r_block;
    rdata_axi = r_word;
    rresp     = r_pend ? resp_cfg : 2'b00;
    bvalid    = b_pend;
    bresp     = b_pend ? resp_cfg : 2'b00;
    ar_hs = arvalid && arready;
    if (ar_hs) last_araddr = araddr;
    aw_hs = awvalid && awready;
    if (aw_hs) hs_awaddr = awaddr;
    w_hs = wvalid && wready;
    if (w_hs) begin
      hs_wdata = wdata_axi;
      hs_wstrb = wstrb;
      check_eq("wstrb", {28'h0, wstrb}, {28'h0, exp_wstrb});
      check_eq("wdata_axi", wdata_axi, exp_wdata);
    end
    r_hs = rvalid && rready;
    b_hs = bvalid && bready;
    prev_ar = arvalid;
    prev_aw = awvalid;
    prev_w  = wvalid;
  endtask

  // Issue one instruction and wait (bounded) for its result to be consumed.
  task automatic do_op(input string tag, input bit is_mem, input bit is_st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] resp, input int hold);
    res_t e;
    bit   done;
    int   held;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    if (is_mem && is_st) begin
      e.err = (resp != 2'b00);
      case (f3)
        3'b000: begin exp_wstrb = 4'b0001 << a[1:0]; exp_wdata = {4{d[7:0]}}; end
        3'b001: begin exp_wstrb = 4'b0011 << {a[1], 1'b0}; exp_wdata = {2{d[15:0]}}; end
        default: begin exp_wstrb = 4'b1111; exp_wdata = d; end
      endcase
    end else if (is_mem) begin
      e.err   = (resp != 2'b00);
      e.rdata = e.err ? 32'h0 : load_fmt(mem[a[5:2]], a[1:0], f3);
    end
    sb_q.push_back(e);
    resp_cfg   = resp;
    prev_valid = 1; req = is_mem; wen = is_st; funct3 = f3; addr = a; wdata = d;
    next_ready = (hold == 0);
    done = 0;
    held = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tick();
      // Request was latched at the previous edge; later upstream values are junk.
      if (cyc == 1) begin addr = ~a; wdata = ~d; funct3 = f3 ^ 3'b001; end
      if (this_valid && !next_ready) begin
        check_eq({tag, "_hold_ready"}, this_ready, 0);
        check_eq({tag, "_hold_rdata"}, rdata, e.rdata);
        check_eq({tag, "_hold_noaxi"}, {arvalid, awvalid}, 0);
        held++;
        if (held == hold) begin
          next_ready = 1;
          #1;
        end
      end
      if (this_valid && this_ready) begin
        e = sb_q.pop_front();
        check_eq({tag, "_rdata"}, rdata, e.rdata);
        check_eq({tag, "_err"}, access_err, e.err);
        if (!is_mem) check_eq({tag, "_noaxi"}, {arvalid, awvalid, wvalid}, 0);
        done = 1;
      end
    end
    if (!done) begin
      check_eq({tag, "_timeout"}, 0, 1);
      void'(sb_q.pop_front());
    end
    @(posedge clk);
    #1;
    prev_valid = 0; req = 0; wen = 0; next_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h11111111 * i;
    mem[0] = 32'h80FF1234;
    mem[1] = 32'h01234567;
    ar_delay = 0; aw_delay = 0; w_delay = 0; resp_cfg = 0;
    slave_clear();
    rst = 1; prev_valid = 0; next_ready = 1; req = 0; wen = 0;
    funct3 = 0; addr = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_eq("rst_this_valid", this_valid, 0);
    check_eq("rst_this_ready", this_ready, 0);
    check_eq("rst_axi_valids", {arvalid, awvalid, wvalid}, 0);
    check_eq("rst_axi_readies", {rready, bready}, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_err", access_err, 0);
    @(posedge clk);
    #1;

    do_op("nop", 0, 0, 3'b000, 32'h00001234, 32'h0, 2'b00, 0);

    ar_delay = 2;
    do_op("lb", 1, 0, 3'b000, 32'h80000003, 32'h0, 2'b00, 5);
    check_eq("lb_araddr", last_araddr, 32'h80000000);
    check_eq("lb_value", load_fmt(32'h80FF1234, 2'd3, 3'b000), 32'hFFFFFF80);
    ar_delay = 0;

    aw_delay = 1; w_delay = 3;
    do_op("sh", 1, 1, 3'b001, 32'h80000002, 32'h0000ABCD, 2'b00, 0);
    check_eq("sh_mem", mem[0], 32'hABCD1234);
    aw_delay = 0; w_delay = 0;

    do_op("lhu_err", 1, 0, 3'b101, 32'h80000002, 32'h0, 2'b10, 0);
    do_op("lw", 1, 0, 3'b010, 32'h80000000, 32'h0, 2'b00, 0);
    do_op("lh", 1, 0, 3'b001, 32'h80000002, 32'h0, 2'b00, 0);
    do_op("lbu", 1, 0, 3'b100, 32'h80000001, 32'h0, 2'b00, 0);
    aw_delay = 2;
    do_op("sb", 1, 1, 3'b000, 32'h80000005, 32'h0000005A, 2'b00, 0);
    check_eq("sb_mem", mem[1], 32'h01235A67);
    aw_delay = 0;
    do_op("lb2", 1, 0, 3'b000, 32'h80000005, 32'h0, 2'b00, 0);
    do_op("lw_f3_011", 1, 0, 3'b011, 32'h80000007, 32'h0, 2'b00, 0);
    w_delay = 1;
    do_op("sw_err", 1, 1, 3'b010, 32'h80000008, 32'hDEADBEEF, 2'b11, 2);
    w_delay = 0;

    // Abandon a load while waiting in RD_DATA.
    r_block = 1;
    resp_cfg = 0;
    prev_valid = 1; req = 1; wen = 0; funct3 = 3'b010; addr = 32'h80000004; next_ready = 1;
    tick();
    tick();
    tick();
    check_eq("rd_data_rready", rready, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0; prev_valid = 0; req = 0;
    slave_clear();
    @(negedge clk);
    check_eq("mid_rst_valids", {arvalid, awvalid, wvalid}, 0);
    check_eq("mid_rst_readies", {rready, bready}, 0);
    check_eq("mid_rst_this_valid", this_valid, 0);
    @(posedge clk);
    #1;
    do_op("nop2", 0, 0, 3'b000, 32'h0, 32'h0, 2'b00, 0);
    do_op("lw_after_rst", 1, 0, 3'b010, 32'h80000000, 32'h0, 2'b00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
